// File: rtl/uart_capture_pkg.sv
`default_nettype none
//==============================================================================
// uart_capture_pkg -- shared receiver state encoding and default sizing. rev 1.0
//==============================================================================
package uart_capture_pkg;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 217;
  localparam int unsigned DEFAULT_FIFO_DEPTH   = 16;

endpackage
`default_nettype wire

// File: rtl/uart_rx_capture_if.sv
`default_nettype none
//==============================================================================
// uart_rx_capture_if -- valid/ready byte stream out of the receive FIFO. rev 1.0
//==============================================================================
interface uart_rx_capture_if;

  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);

endinterface
`default_nettype wire

// File: rtl/uart_capture_fifo.sv
`default_nettype none
//==============================================================================
// uart_capture_fifo -- power-of-two synchronous FIFO with exact level. rev 1.0
//==============================================================================
module uart_capture_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  wire              clk,
  input  wire              rst_n,
  input  wire              push_i,
  input  wire  [WIDTH-1:0] wdata_i,
  input  wire              pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == FULL_LVL);
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_capture.sv
`default_nettype none
//==============================================================================
// uart_rx_capture -- 8N1 UART receiver feeding a byte FIFO; cts_n output only
// when UART_RX_CAPTURE_FLOW_CTRL_EN is defined. rev 1.0
//==============================================================================
module uart_rx_capture
  import uart_capture_pkg::*;
#(
  parameter  int unsigned CLKS_PER_BIT  = DEFAULT_CLKS_PER_BIT,
  parameter  int unsigned FIFO_DEPTH    = DEFAULT_FIFO_DEPTH,
  parameter  int unsigned RTS_THRESHOLD = FIFO_DEPTH - 2,
  localparam int unsigned LW            = $clog2(FIFO_DEPTH) + 1
) (
  input  wire                clk,
  input  wire                rst_n,
  input  wire                rxd_i,
  input  wire                clear_i,
  uart_rx_capture_if.master  out_if,
  output logic               frame_error_o,
  output logic               overrun_o,
  output logic [LW-1:0]      level_o
`ifdef UART_RX_CAPTURE_FLOW_CTRL_EN
  ,
  output logic               cts_n_o
`endif
);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
    $error("CLKS_PER_BIT must be within 4..65535");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two within 2..256");
  end
  if (RTS_THRESHOLD > FIFO_DEPTH) begin : g_bad_rts_threshold
    $error("RTS_THRESHOLD must not exceed FIFO_DEPTH");
  end

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

  logic rst_meta_q;
  logic rst_sync_q;

  // Reset asserts straight through, but releases only after two clean edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  logic        rxd_meta_q;
  logic        rxd_sync_q;
  logic        rxd_prev_q;
  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        frame_error_q;
  logic        overrun_q;
  logic        push;
  logic        pop;
  logic        fe_set;
  logic        ovr_set;
  logic        fifo_full;
  logic        fifo_empty;
  logic [LW-1:0] fifo_level;

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      rxd_meta_q    <= 1'b1;
      rxd_sync_q    <= 1'b1;
      rxd_prev_q    <= 1'b1;
      state_q       <= RX_IDLE;
      cnt_q         <= '0;
      bitcnt_q      <= '0;
      shift_q       <= '0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      rxd_meta_q    <= rxd_i;
      rxd_sync_q    <= rxd_meta_q;
      rxd_prev_q    <= rxd_sync_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bitcnt_q      <= bitcnt_d;
      shift_q       <= shift_d;
      frame_error_q <= fe_set  | (frame_error_q & ~clear_i);
      overrun_q     <= ovr_set | (overrun_q & ~clear_i);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    push     = 1'b0;
    fe_set   = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (rxd_prev_q && !rxd_sync_q) begin
          state_d  = RX_START;
          cnt_d    = '0;
          bitcnt_d = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d    = '0;
          shift_d  = {rxd_sync_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxd_sync_q) begin
            push    = 1'b1;
            state_d = RX_IDLE;
          end else begin
            fe_set  = 1'b1;
            state_d = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_BREAK: begin
        // Hold off new starts until the line has returned to idle.
        if (rxd_sync_q) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign pop     = !fifo_empty && out_if.out_ready;
  assign ovr_set = push && fifo_full && !pop;

  uart_capture_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_sync_q),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (pop),
    .rdata_o (out_if.out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign out_if.out_valid = !fifo_empty;
  assign frame_error_o    = frame_error_q;
  assign overrun_o        = overrun_q;
  assign level_o          = fifo_level;

`ifdef UART_RX_CAPTURE_FLOW_CTRL_EN
  localparam logic [LW-1:0] RTS_LVL = LW'(RTS_THRESHOLD);

  logic cts_n_q;

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      cts_n_q <= 1'b0;
    end else begin
      cts_n_q <= (fifo_level >= RTS_LVL);
    end
  end

  assign cts_n_o = cts_n_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_capture.sv
`default_nettype none
//==============================================================================
// tb_uart_rx_capture -- directed self-checking bench, CLKS_PER_BIT=4, depth 4.
//==============================================================================
module tb_uart_rx_capture;
  import uart_capture_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       clear = 1'b0;
  logic       frame_error;
  logic       overrun;
  logic [2:0] level;
`ifdef UART_RX_CAPTURE_FLOW_CTRL_EN
  logic       cts_n;
`endif
  int checks = 0;
  int failures = 0;

  uart_rx_capture_if bus ();

  uart_rx_capture #(
    .CLKS_PER_BIT  (4),
    .FIFO_DEPTH    (4),
    .RTS_THRESHOLD (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rxd_i         (rxd),
    .clear_i       (clear),
    .out_if        (bus),
    .frame_error_o (frame_error),
    .overrun_o     (overrun),
    .level_o       (level)
`ifdef UART_RX_CAPTURE_FLOW_CTRL_EN
    ,
    .cts_n_o       (cts_n)
`endif
  );

  always #5 clk = ~clk;

  // Frame bits change on falling edges; call n drives cycle n of the frame.
  task automatic send_frame(input logic [7:0] data, input logic stop);
    logic [9:0] fr;
    fr = {stop, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        rxd = fr[b];
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus.out_data); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if ({frame_error, overrun} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {frame_error, overrun}); end
`ifdef UART_RX_CAPTURE_FLOW_CTRL_EN
    checks++; if (cts_n !== 1'b0) begin failures++; $display("FAIL reset_cts got=%b exp=0", cts_n); end
`endif
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Stop sample falls 2 sync + 1 edge + 2 half-bit + 9*4 = 41 edges in.
  task automatic test_single_byte;
    logic [9:0] fr;
    int first;
    fr = {1'b1, 8'hA5, 1'b0};
    first = -1;
    for (int n = 0; n < 48; n++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && first < 0) first = n;
      rxd = (n < 40) ? fr[n / 4] : 1'b1;
    end
    checks++; if (first !== 41) begin failures++; $display("FAIL single_latency got=%0d exp=41", first); end
    checks++; if (bus.out_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", bus.out_data); end
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL single_level got=%0d exp=1", level); end
    checks++; if ({frame_error, overrun} !== 2'b00) begin failures++; $display("FAIL single_flags got=%b exp=00", {frame_error, overrun}); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL single_pop_level got=%0d exp=0", level); end
  endtask

  task automatic test_glitch;
    @(negedge clk); rxd = 1'b0;
    @(negedge clk); rxd = 1'b1;
    repeat (12) @(negedge clk);
    checks++; if (dut.state_q !== RX_IDLE) begin failures++; $display("FAIL glitch_state got=%0d exp=%0d", dut.state_q, RX_IDLE); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL glitch_level got=%0d exp=0", level); end
    checks++; if ({frame_error, overrun} !== 2'b00) begin failures++; $display("FAIL glitch_flags got=%b exp=00", {frame_error, overrun}); end
  endtask

  task automatic test_frame_error;
    send_frame(8'h3C, 1'b0);
    repeat (80) @(negedge clk);
    checks++; if (frame_error !== 1'b1) begin failures++; $display("FAIL fe_set got=%b exp=1", frame_error); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL fe_level got=%0d exp=0", level); end
    checks++; if (dut.state_q !== RX_BREAK) begin failures++; $display("FAIL fe_break got=%0d exp=%0d", dut.state_q, RX_BREAK); end
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    send_frame(8'h11, 1'b1);
    @(negedge clk); rxd = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL fe_next_level got=%0d exp=1", level); end
    checks++; if (bus.out_data !== 8'h11) begin failures++; $display("FAIL fe_next_data got=%h exp=11", bus.out_data); end
    bus.out_ready = 1'b1;
    @(negedge clk); bus.out_ready = 1'b0; clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL fe_clear got=%b exp=0", frame_error); end
    // clear lands on the same edge as the bad stop sample
    send_frame(8'h3C, 1'b0);
    @(negedge clk); clear = 1'b1; rxd = 1'b1;
    @(negedge clk); clear = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (frame_error !== 1'b1) begin failures++; $display("FAIL fe_set_wins got=%b exp=1", frame_error); end
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL fe_clear2 got=%b exp=0", frame_error); end
  endtask

  task automatic test_overrun;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    @(negedge clk); rxd = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL ovr_level got=%0d exp=4", level); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (bus.out_data !== 8'(i)) begin failures++; $display("FAIL ovr_pop%0d got=%h exp=%h", i, bus.out_data, 8'(i)); end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL ovr_empty got=%b exp=0", bus.out_valid); end
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
  endtask

  task automatic test_back_to_back_full;
    logic [7:0] exp_q [4];
    exp_q = '{8'h20, 8'h30, 8'h40, 8'h77};
    send_frame(8'h10, 1'b1);
    send_frame(8'h20, 1'b1);
    send_frame(8'h30, 1'b1);
    send_frame(8'h40, 1'b1);
    send_frame(8'h77, 1'b1);
    @(negedge clk); bus.out_ready = 1'b1; rxd = 1'b1;
    @(negedge clk); bus.out_ready = 1'b0;
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", level); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL full_overrun got=%b exp=0", overrun); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.out_data !== exp_q[i]) begin failures++; $display("FAIL full_pop%0d got=%h exp=%h", i, bus.out_data, exp_q[i]); end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL full_drain got=%0d exp=0", level); end
  endtask

`ifdef UART_RX_CAPTURE_FLOW_CTRL_EN
  task automatic test_flow_ctrl;
    send_frame(8'hA1, 1'b1);
    send_frame(8'hA2, 1'b1);
    @(negedge clk); rxd = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (cts_n !== 1'b0) begin failures++; $display("FAIL cts_two got=%b exp=0", cts_n); end
    send_frame(8'hA3, 1'b1);
    @(negedge clk); rxd = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (cts_n !== 1'b1) begin failures++; $display("FAIL cts_three got=%b exp=1", cts_n); end
    bus.out_ready = 1'b1;
    @(negedge clk); bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (cts_n !== 1'b0) begin failures++; $display("FAIL cts_pop got=%b exp=0", cts_n); end
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.out_ready = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_frame;
    logic [9:0] fr;
    send_frame(8'h5A, 1'b1);
    @(negedge clk); rxd = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL mid_pre_level got=%0d exp=1", level); end
    fr = {1'b1, 8'h00, 1'b0};
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      rxd = fr[n / 4];
    end
    @(negedge clk);
    checks++; if (dut.state_q !== RX_DATA) begin failures++; $display("FAIL mid_in_data got=%0d exp=%0d", dut.state_q, RX_DATA); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL mid_data got=%h exp=00", bus.out_data); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL mid_level got=%0d exp=0", level); end
    checks++; if ({frame_error, overrun} !== 2'b00) begin failures++; $display("FAIL mid_flags got=%b exp=00", {frame_error, overrun}); end
`ifdef UART_RX_CAPTURE_FLOW_CTRL_EN
    checks++; if (cts_n !== 1'b0) begin failures++; $display("FAIL mid_cts got=%b exp=0", cts_n); end
`endif
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL mid_post_level got=%0d exp=0", level); end
    send_frame(8'h11, 1'b1);
    @(negedge clk); rxd = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL mid_next_level got=%0d exp=1", level); end
    checks++; if (bus.out_data !== 8'h11) begin failures++; $display("FAIL mid_next_data got=%h exp=11", bus.out_data); end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_back_to_back_full();
`ifdef UART_RX_CAPTURE_FLOW_CTRL_EN
    test_flow_ctrl();
`endif
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
